// File: rtl/adc_capture.sv
// Purpose : triggered single-shot waveform capture of the ADC bus into a 64 x 8 buffer,
//           with arming, level/immediate trigger, decimation and min/max tracking.
// Latency : pin to buffer write is 1 clock; rd_data returns 1 clock after rd_addr.
// Flow    : no backpressure; adc_data is consumed every clock, capture is one-shot.
// Ports   : clk/reset (async, active-high); adc_data sample in; arm/abort control pulses;
//           trig_mode/trig_level/decim capture setup; rd_addr/rd_data readout port;
//           busy/done status; s_min/s_max stored-sample extremes of the last capture.
module adc_capture #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEC_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DEC_W-1:0]  decim,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] s_min,
    output logic [DATA_W-1:0] s_max
);

    localparam int DEPTH = 2**ADDR_W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] adc_q, adc_p_q;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [DEC_W-1:0]  dcnt_q, dcnt_d;
    logic [DEC_W-1:0]  dec_q, dec_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic              busy_q, done_q;
    logic [DATA_W-1:0] rd_q;

    logic              trig;
    logic              we;
    logic [ADDR_W-1:0] waddr;

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        dcnt_d  = dcnt_q;
        dec_d   = dec_q;
        mode_d  = mode_q;
        min_d   = min_q;
        max_d   = max_q;
        we      = 1'b0;
        waddr   = wptr_q;
        // Immediate mode fires on the first armed cycle; level mode needs an
        // upward crossing between the two most recent samples.
        trig    = mode_q || ((adc_p_q < trig_level) && (adc_q >= trig_level));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d = ST_ARMED;
                    dec_d   = decim;
                    mode_d  = trig_mode;
                end
            end
            ST_ARMED: begin
                // abort has priority over a coincident trigger: nothing is written.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (trig) begin
                    we      = 1'b1;
                    waddr   = '0;
                    min_d   = adc_q;
                    max_d   = adc_q;
                    wptr_d  = ADDR_W'(1);
                    dcnt_d  = dec_q;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (dcnt_q == '0) begin
                    we     = 1'b1;
                    waddr  = wptr_q;
                    if (adc_q < min_q) min_d = adc_q;
                    if (adc_q > max_q) max_d = adc_q;
                    wptr_d = wptr_q + 1'b1;
                    dcnt_d = dec_q;
                    // Last slot written: stop rather than wrap.
                    if (wptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_DONE;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            adc_q   <= '0;
            adc_p_q <= '0;
            wptr_q  <= '0;
            dcnt_q  <= '0;
            dec_q   <= '0;
            mode_q  <= 1'b0;
            min_q   <= '0;
            max_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            adc_q   <= adc_data;
            adc_p_q <= adc_q;
            wptr_q  <= wptr_d;
            dcnt_q  <= dcnt_d;
            dec_q   <= dec_d;
            mode_q  <= mode_d;
            min_q   <= min_d;
            max_q   <= max_d;
            // Status flops follow the next state so they line up with state_q.
            busy_q  <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
            done_q  <= (state_d == ST_DONE);
            // Read-before-write: a same-address write this edge is not visible yet.
            rd_q    <= mem[rd_addr];
        end
    end

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= adc_q;
    end

    assign rd_data = rd_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign s_min   = min_q;
    assign s_max   = max_q;

endmodule
